// File: rtl/test_pattern_pkg.sv
// rtl/test_pattern_pkg.sv - shared command layout, states, patterns and colour table
package test_pattern_pkg;

  // Command word field layout
  localparam int W_LSB     = 0;
  localparam int W_BITS    = 16;
  localparam int H_LSB     = 16;
  localparam int H_BITS    = 16;
  localparam int PAT_LSB   = 32;
  localparam int PAT_BITS  = 4;
  localparam int COL_LSB   = 36;
  localparam int COL_BITS  = 24;
  localparam int STEP_LSB  = 60;
  localparam int STEP_BITS = 8;
  localparam int IL_LSB    = 68;
  localparam int IL_BITS   = 4;
  localparam int CTRL_BIT  = 76;

  // Each state names the beat currently held in the output register
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL_HDR,
    ST_CTRL_B0,
    ST_CTRL_B1,
    ST_CTRL_B2,
    ST_VID_HDR,
    ST_VID_PIX
  } state_t;

  localparam logic [3:0] PAT_SOLID   = 4'd0;
  localparam logic [3:0] PAT_BARS    = 4'd1;
  localparam logic [3:0] PAT_RAMP    = 4'd2;
  localparam logic [3:0] PAT_CHECKER = 4'd3;

  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_CTRL  = 4'hF;

  // Colour-bar table, {R,G,B}
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/test_pattern_pixel_calc.sv
// rtl/test_pattern_pixel_calc.sv - pixel value for a coordinate, with ramp accumulator
module test_pattern_pixel_calc
  import test_pattern_pkg::*;
#(
  parameter int BPS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic [15:0]      x,
  input  logic [15:0]      y,
  input  logic [2:0]       bar,
  input  logic [3:0]       pattern,
  input  logic [3*BPS-1:0] colour,
  input  logic [BPS-1:0]   step,
  output logic [3*BPS-1:0] pixel
);

  logic [BPS-1:0] acc_q;
  logic [BPS-1:0] ramp;
  logic           unused_y;

  // Only y[3] matters for the checkerboard
  assign unused_y = ^{y[15:4], y[2:0]};

  // Ramp restarts at the left edge of every line
  assign ramp = (x == 16'd0) ? '0 : acc_q + step;

  // Remember the ramp value of the pixel just loaded into the output register
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (adv) begin
      acc_q <= ramp;
    end
  end

  // Pattern select; unknown codes fall back to solid
  always_comb begin
    pixel = colour;
    case (pattern)
      PAT_SOLID:   pixel = colour;
      PAT_BARS:    pixel = bar_colour(bar);
      PAT_RAMP:    pixel = {ramp, ramp, ramp};
      PAT_CHECKER: pixel = (x[3] ^ y[3]) ? ~colour : colour;
      default:     pixel = colour;
    endcase
  end

endmodule

// File: rtl/test_pattern_cmd_reader.sv
// rtl/test_pattern_cmd_reader.sv - pops frame commands and emits control/video packets
module test_pattern_cmd_reader
  import test_pattern_pkg::*;
#(
  parameter int BPS       = 8,
  parameter int CMD_WIDTH = 77
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [CMD_WIDTH-1:0] cmd_data,
  output logic                 cmd_ready,
  output logic [3*BPS-1:0]     dout_data,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_startofpacket,
  output logic                 dout_endofpacket,
  output logic                 busy,
  output logic [15:0]          frame_count
);

  state_t st_q, st_d;

  logic [15:0]      w_q, h_q, x_q, y_q, sub_q;
  logic [3:0]       pat_q, il_q;
  logic [3*BPS-1:0] col_q;
  logic [BPS-1:0]   step_q;
  logic [2:0]       bar_q;

  logic [15:0] cmd_w, cmd_h, bar_len;
  logic        cmd_ctrl, accept, xfer, last_x, last_pix, bar_end;
  logic [15:0] pc_x, pc_y, pc_sub;
  logic [2:0]  pc_bar;
  logic        pc_last, adv;
  logic [3*BPS-1:0] pixel;
  logic [3*BPS-1:0] data_d;
  logic             valid_d, sop_d, eop_d;
  logic             unused_rsvd;

  assign cmd_w       = cmd_data[W_LSB +: W_BITS];
  assign cmd_h       = cmd_data[H_LSB +: H_BITS];
  assign cmd_ctrl    = cmd_data[CTRL_BIT];
  assign unused_rsvd = ^cmd_data[75:72];

  assign cmd_ready = (st_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (st_q != ST_IDLE) || cmd_valid;
  assign xfer      = dout_valid && dout_ready;

  // Raster position bookkeeping for the pixel currently on the output
  assign last_x   = (x_q == w_q - 16'd1);
  assign last_pix = last_x && (y_q == h_q - 16'd1);
  assign bar_len  = (w_q[15:3] == 13'd0) ? 16'd1 : {3'b000, w_q[15:3]};
  assign bar_end  = (sub_q == bar_len - 16'd1);

  // Coordinates of the next pixel to load (origin when leaving the video header)
  always_comb begin
    pc_x   = 16'd0;
    pc_y   = 16'd0;
    pc_sub = 16'd0;
    pc_bar = 3'd0;
    if (st_q == ST_VID_PIX) begin
      pc_x   = last_x ? 16'd0 : x_q + 16'd1;
      pc_y   = last_x ? y_q + 16'd1 : y_q;
      pc_sub = (last_x || bar_end) ? 16'd0 : sub_q + 16'd1;
      pc_bar = last_x ? 3'd0 : ((bar_end && bar_q != 3'd7) ? bar_q + 3'd1 : bar_q);
    end
  end

  assign pc_last = (pc_x == w_q - 16'd1) && (pc_y == h_q - 16'd1);
  assign adv     = xfer && ((st_q == ST_VID_HDR) || (st_q == ST_VID_PIX && !last_pix));

  test_pattern_pixel_calc #(.BPS(BPS)) u_pixel_calc (
    .clk     (clk),
    .reset   (reset),
    .adv     (adv),
    .x       (pc_x),
    .y       (pc_y),
    .bar     (pc_bar),
    .pattern (pat_q),
    .colour  (col_q),
    .step    (step_q),
    .pixel   (pixel)
  );

  // Next state and next output beat; the beat holds unless it is transferred
  always_comb begin
    st_d    = st_q;
    valid_d = dout_valid;
    data_d  = dout_data;
    sop_d   = dout_startofpacket;
    eop_d   = dout_endofpacket;
    case (st_q)
      ST_IDLE: begin
        if (accept && cmd_w != 16'd0 && cmd_h != 16'd0) begin
          st_d    = cmd_ctrl ? ST_CTRL_HDR : ST_VID_HDR;
          valid_d = 1'b1;
          data_d  = {20'h0, cmd_ctrl ? PKT_CTRL : PKT_VIDEO};
          sop_d   = 1'b1;
          eop_d   = 1'b0;
        end
      end
      ST_CTRL_HDR: if (xfer) begin
        st_d   = ST_CTRL_B0;
        data_d = {4'h0, w_q[7:4], 4'h0, w_q[11:8], 4'h0, w_q[15:12]};
        sop_d  = 1'b0;
      end
      ST_CTRL_B0: if (xfer) begin
        st_d   = ST_CTRL_B1;
        data_d = {4'h0, h_q[11:8], 4'h0, h_q[15:12], 4'h0, w_q[3:0]};
      end
      ST_CTRL_B1: if (xfer) begin
        st_d   = ST_CTRL_B2;
        data_d = {4'h0, il_q, 4'h0, h_q[3:0], 4'h0, h_q[7:4]};
        eop_d  = 1'b1;
      end
      ST_CTRL_B2: if (xfer) begin
        st_d   = ST_VID_HDR;
        data_d = {20'h0, PKT_VIDEO};
        sop_d  = 1'b1;
        eop_d  = 1'b0;
      end
      ST_VID_HDR: if (xfer) begin
        st_d   = ST_VID_PIX;
        data_d = pixel;
        sop_d  = 1'b0;
        eop_d  = pc_last;
      end
      ST_VID_PIX: if (xfer) begin
        if (last_pix) begin
          st_d    = ST_IDLE;
          valid_d = 1'b0;
          data_d  = '0;
          eop_d   = 1'b0;
        end else begin
          data_d = pixel;
          eop_d  = pc_last;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // State and registered output beat
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q               <= ST_IDLE;
      dout_valid         <= 1'b0;
      dout_data          <= '0;
      dout_startofpacket <= 1'b0;
      dout_endofpacket   <= 1'b0;
    end else begin
      st_q               <= st_d;
      dout_valid         <= valid_d;
      dout_data          <= data_d;
      dout_startofpacket <= sop_d;
      dout_endofpacket   <= eop_d;
    end
  end

  // Command latch, raster counters and completed-frame count
  always_ff @(posedge clk) begin
    if (reset) begin
      w_q         <= '0;
      h_q         <= '0;
      pat_q       <= '0;
      col_q       <= '0;
      step_q      <= '0;
      il_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      sub_q       <= '0;
      bar_q       <= '0;
      frame_count <= '0;
    end else begin
      if (accept) begin
        w_q    <= cmd_w;
        h_q    <= cmd_h;
        pat_q  <= cmd_data[PAT_LSB +: PAT_BITS];
        col_q  <= cmd_data[COL_LSB +: COL_BITS];
        step_q <= cmd_data[STEP_LSB +: STEP_BITS];
        il_q   <= cmd_data[IL_LSB +: IL_BITS];
      end
      if (adv) begin
        x_q   <= pc_x;
        y_q   <= pc_y;
        sub_q <= pc_sub;
        bar_q <= pc_bar;
      end
      if (xfer && st_q == ST_VID_PIX && last_pix) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_test_pattern_cmd_reader.sv
// tb/tb_test_pattern_cmd_reader.sv - randomized self-checking bench for test_pattern_cmd_reader
module tb_test_pattern_cmd_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [76:0] cmd_data;
  logic        cmd_ready;
  logic [23:0] dout_data;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_startofpacket;
  logic        dout_endofpacket;
  logic        busy;
  logic [15:0] frame_count;

  test_pattern_cmd_reader dut (
    .clk                (clk),
    .reset              (reset),
    .cmd_valid          (cmd_valid),
    .cmd_data           (cmd_data),
    .cmd_ready          (cmd_ready),
    .dout_data          (dout_data),
    .dout_valid         (dout_valid),
    .dout_ready         (dout_ready),
    .dout_startofpacket (dout_startofpacket),
    .dout_endofpacket   (dout_endofpacket),
    .busy               (busy),
    .frame_count        (frame_count)
  );

  always #5 clk = ~clk;

  typedef logic [25:0] beat_t; // {sop, eop, data}

  int    vectors = 0;
  int    errors  = 0;
  int    fc_exp  = 0;
  int    stall_err;
  int    cycles_used;
  beat_t exp_q[$];
  beat_t got_q[$];
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [76:0] mk_cmd(input int w, input int h, input int pat, input logic [23:0] col,
                                         input int step, input int il, input bit ctrl);
    logic [76:0] c;
    c = '0;
    c[15:0] = 16'(w); c[31:16] = 16'(h); c[35:32] = 4'(pat); c[59:36] = col;
    c[67:60] = 8'(step); c[71:68] = 4'(il); c[76] = ctrl;
    return c;
  endfunction

  // Expected beat list for one command, straight from the frame rules
  task automatic model(input logic [76:0] c);
    int w, h, pat, step, il, bar_len, bar, acc, d;
    logic [23:0] col, px;
    w = int'(c[15:0]); h = int'(c[31:16]); pat = int'(c[35:32]); col = c[59:36];
    step = int'(c[67:60]); il = int'(c[71:68]);
    exp_q.delete();
    if (w == 0 || h == 0) return;
    if (c[76]) begin
      exp_q.push_back({2'b10, 24'h00000F});
      d = ((w >> 12) & 15) | (((w >> 8) & 15) << 8) | (((w >> 4) & 15) << 16);
      exp_q.push_back({2'b00, 24'(d)});
      d = (w & 15) | (((h >> 12) & 15) << 8) | (((h >> 8) & 15) << 16);
      exp_q.push_back({2'b00, 24'(d)});
      d = ((h >> 4) & 15) | ((h & 15) << 8) | (il << 16);
      exp_q.push_back({2'b01, 24'(d)});
    end
    exp_q.push_back({2'b10, 24'h000000});
    bar_len = (w / 8 < 1) ? 1 : w / 8;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        case (pat)
          1: begin bar = x / bar_len; if (bar > 7) bar = 7; px = bars[bar]; end
          2: begin acc = (x * step) % 256; px = {8'(acc), 8'(acc), 8'(acc)}; end
          3: px = ((((x >> 3) ^ (y >> 3)) & 1) == 1) ? ~col : col;
          default: px = col;
        endcase
        exp_q.push_back({1'b0, (x == w - 1 && y == h - 1), px});
      end
    end
  endtask

  // Present a command and wait (bounded) for it to be taken
  task automatic send_cmd(input logic [76:0] c);
    cmd_data  = c;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    vectors++; errors++;
    $display("FAIL cmd_accept: cmd_ready=%0b required 1 within 50 cycles", cmd_ready);
    cmd_valid = 1'b0;
  endtask

  // Gather up to n transferred beats under random backpressure, noting any stall instability
  task automatic collect(input int n, input int ready_pct, input int budget);
    logic        r, prev_stall;
    logic [26:0] cur, prev;
    got_q.delete();
    stall_err = 0; cycles_used = 0; prev_stall = 1'b0; prev = '0;
    for (int i = 0; i < budget && got_q.size() < n; i++) begin
      r = ($urandom_range(99) < ready_pct);
      dout_ready = r;
      cur = {dout_valid, dout_startofpacket, dout_endofpacket, dout_data};
      if (prev_stall && cur !== prev) stall_err++;
      if (dout_valid && r) got_q.push_back({dout_startofpacket, dout_endofpacket, dout_data});
      prev_stall = dout_valid && !r;
      prev = cur;
      @(posedge clk); #1;
      cycles_used++;
    end
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({dout_valid, dout_startofpacket, dout_endofpacket, dout_data} !== 27'd0)
      begin errors++; $display("FAIL reset_dout: got %h required 0", {dout_valid, dout_startofpacket, dout_endofpacket, dout_data}); end
    vectors++;
    if ({cmd_ready, busy, frame_count} !== {1'b1, 1'b0, 16'd0})
      begin errors++; $display("FAIL reset_ctl: ready=%0b busy=%0b fc=%0d required 1 0 0", cmd_ready, busy, frame_count); end
    fc_exp = 0;
  endtask

  task automatic test_solid();
    logic [76:0] c;
    c = mk_cmd(4, 2, 0, 24'h123456, 0, 0, 1'b0);
    model(c);
    send_cmd(c);
    vectors++;
    if (dout_valid !== 1'b1 || dout_startofpacket !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL solid_latency: valid=%0b sop=%0b busy=%0b required 1 1 1", dout_valid, dout_startofpacket, busy); end
    collect(exp_q.size(), 100, 100);
    fc_exp++;
    vectors++;
    if (got_q.size() != 9 || cycles_used != 9)
      begin errors++; $display("FAIL solid_count: beats=%0d cycles=%0d required 9 9", got_q.size(), cycles_used); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL solid_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    vectors++;
    if (got_q.size() == 9 && (got_q[0] !== {2'b10, 24'h0} || got_q[8] !== {2'b01, 24'h123456}))
      begin errors++; $display("FAIL solid_ends: got %h %h required 2000000 1123456", got_q[0], got_q[8]); end
    vectors++;
    if (frame_count !== 16'(fc_exp) || cmd_ready !== 1'b1)
      begin errors++; $display("FAIL solid_done: fc=%0d ready=%0b required %0d 1", frame_count, cmd_ready, fc_exp); end
  endtask

  task automatic test_ctrl();
    logic [76:0] c;
    c = mk_cmd(4, 2, 0, 24'h123456, 0, 5, 1'b1);
    model(c);
    send_cmd(c);
    collect(exp_q.size(), 100, 100);
    fc_exp++;
    vectors++;
    if (got_q.size() != 13 || cycles_used != 13)
      begin errors++; $display("FAIL ctrl_count: beats=%0d cycles=%0d required 13 13", got_q.size(), cycles_used); end
    vectors++;
    if (got_q.size() == 13 && (got_q[0] !== {2'b10, 24'h00000F} || got_q[1] !== {2'b00, 24'h0} ||
        got_q[2] !== {2'b00, 24'h000004} || got_q[3] !== {2'b01, 24'h050200} || got_q[4] !== {2'b10, 24'h0}))
      begin errors++; $display("FAIL ctrl_packet: got %h %h %h %h %h", got_q[0], got_q[1], got_q[2], got_q[3], got_q[4]); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ctrl_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_bars_ramp();
    logic [76:0] cl [3];
    cl[0] = mk_cmd(16, 1, 1, 24'h0, 0, 0, 1'b0);
    cl[1] = mk_cmd(4, 1, 1, 24'h0, 0, 0, 1'b0);
    cl[2] = mk_cmd(5, 1, 2, 24'h0, 8'h60, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      model(cl[k]);
      send_cmd(cl[k]);
      collect(exp_q.size(), 100, 100);
      fc_exp++;
      vectors++;
      if (got_q.size() != exp_q.size())
        begin errors++; $display("FAIL pat%0d_count: beats=%0d required %0d", k, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL pat%0d_beat%0d: got %h required %h", k, i, got_q[i], exp_q[i]); end
      end
    end
    vectors++;
    if (got_q.size() == 6 && (got_q[2] !== {2'b00, 24'h606060} || got_q[4] !== {2'b00, 24'h202020}))
      begin errors++; $display("FAIL ramp_values: got %h %h required 606060 202020", got_q[2], got_q[4]); end
  endtask

  task automatic test_checker_stall();
    logic [76:0] c;
    c = mk_cmd(20, 20, 3, 24'($urandom), 0, 0, 1'b0);
    model(c);
    send_cmd(c);
    collect(exp_q.size(), 60, 3000);
    fc_exp++;
    vectors++;
    if (stall_err != 0) begin errors++; $display("FAIL checker_stall: unstable=%0d required 0", stall_err); end
    vectors++;
    if (got_q.size() != exp_q.size())
      begin errors++; $display("FAIL checker_count: beats=%0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL checker_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    vectors++;
    if (frame_count !== 16'(fc_exp)) begin errors++; $display("FAIL checker_fc: got %0d required %0d", frame_count, fc_exp); end
  endtask

  task automatic test_zero_size();
    int seen;
    send_cmd(mk_cmd(0, 5, 0, 24'hABCDEF, 0, 0, 1'b0));
    send_cmd(mk_cmd(7, 0, 1, 24'hABCDEF, 0, 0, 1'b1));
    seen = 0;
    dout_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (dout_valid) seen++;
      @(posedge clk); #1;
    end
    dout_ready = 1'b0;
    vectors++;
    if (seen != 0 || cmd_ready !== 1'b1 || frame_count !== 16'(fc_exp))
      begin errors++; $display("FAIL zero_size: beats=%0d ready=%0b fc=%0d required 0 1 %0d", seen, cmd_ready, frame_count, fc_exp); end
  endtask

  task automatic test_back_to_back();
    logic [76:0] c;
    for (int k = 0; k < 8; k++) begin
      c = mk_cmd($urandom_range(12, 1), $urandom_range(6, 1), $urandom_range(15), 24'($urandom),
                 $urandom_range(255), $urandom_range(15), 1'($urandom));
      model(c);
      send_cmd(c);
      collect(exp_q.size(), 70, 1000);
      fc_exp++;
      vectors++;
      if (got_q.size() != exp_q.size() || stall_err != 0)
        begin errors++; $display("FAIL b2b%0d_count: beats=%0d unstable=%0d required %0d 0", k, got_q.size(), stall_err, exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b%0d_beat%0d: got %h required %h", k, i, got_q[i], exp_q[i]); end
      end
      vectors++;
      if (frame_count !== 16'(fc_exp) || cmd_ready !== 1'b1)
        begin errors++; $display("FAIL b2b%0d_done: fc=%0d ready=%0b required %0d 1", k, frame_count, cmd_ready, fc_exp); end
    end
  endtask

  task automatic test_reset_mid_frame();
    send_cmd(mk_cmd(8, 4, 0, 24'h55AA55, 0, 0, 1'b1));
    collect(6, 100, 20);
    dout_ready = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dout_ready = 1'b0;
    fc_exp = 0;
    vectors++;
    if ({dout_valid, dout_startofpacket, dout_endofpacket, dout_data} !== 27'd0 ||
        {cmd_ready, busy, frame_count} !== {1'b1, 1'b0, 16'd0})
      begin errors++; $display("FAIL midreset: dout=%h ready=%0b busy=%0b fc=%0d required 0 1 0 0",
                               {dout_valid, dout_startofpacket, dout_endofpacket, dout_data}, cmd_ready, busy, frame_count); end
  endtask

  task automatic test_one_by_one();
    logic [76:0] c;
    c = mk_cmd(1, 1, 3, 24'h00FF00, 0, 0, 1'b0);
    model(c);
    send_cmd(c);
    collect(2, 100, 20);
    fc_exp++;
    vectors++;
    if (got_q.size() != 2 || got_q[0] !== {2'b10, 24'h0} || got_q[1] !== {2'b01, 24'h00FF00})
      begin errors++; $display("FAIL one_by_one: beats=%0d required 2 (hdr sop, 00FF00 eop)", got_q.size()); end
    vectors++;
    if (frame_count !== 16'(fc_exp)) begin errors++; $display("FAIL one_by_one_fc: got %0d required %0d", frame_count, fc_exp); end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; dout_ready = 1'b0;
    test_reset();
    test_solid();
    test_ctrl();
    test_bars_ramp();
    test_checker_stall();
    test_zero_size();
    test_back_to_back();
    test_reset_mid_frame();
    test_one_by_one();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
